// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts play time down on 1 Hz ticks, keeps binary and
// BCD (m:ss) views of the remaining time in step, and pulses time_up on expiry.
module game_countdown_timer #(
  parameter int unsigned START_SECONDS = 60,
  parameter int unsigned MAX_SECONDS   = 599,
  parameter int unsigned WARN_SECONDS  = 10,
  parameter int unsigned BONUS_SECONDS = 15
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       one_second_enable,
  input  logic       start,
  input  logic       pause,
  input  logic       add_time,
  output logic [9:0] seconds_left,
  output logic [3:0] minutes,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       warning,
  output logic       time_up,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [9:0]  StartVal = 10'(START_SECONDS);
  localparam logic [10:0] MaxVal   = 11'(MAX_SECONDS);
  localparam logic [11:0] StartBcd = {4'(START_SECONDS / 60), 4'((START_SECONDS % 60) / 10),
                                      4'(START_SECONDS % 10)};

  // Binary to {minutes, tens, ones}; constant divisors keep this purely combinational.
  function automatic logic [11:0] to_bcd(input logic [9:0] val);
    logic [31:0] v, r;
    v = 32'(val);
    r = v % 32'd60;
    return {4'(v / 32'd60), 4'(r / 32'd10), 4'(r % 32'd10)};
  endfunction

  function automatic logic [9:0] saturate(input logic [10:0] sum);
    return (sum > MaxVal) ? MaxVal[9:0] : sum[9:0];
  endfunction

  state_e      state_q, state_d;
  logic [9:0]  secs_q, secs_d;
  logic [3:0]  min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic        run_q, run_d, warn_q, warn_d, tup_q, tup_d;

  logic        load;
  logic [9:0]  load_val;
  logic [10:0] sum_add, sum_dec_add;
  logic [3:0]  dec_min, dec_tens, dec_ones;

  assign sum_add     = {1'b0, secs_q} + 11'(BONUS_SECONDS);
  assign sum_dec_add = sum_add - 11'd1;

  // Cascaded digit decrement with borrow.
  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q - 4'd1;
    if (ones_q == 4'd0) begin
      dec_ones = 4'd9;
      dec_tens = tens_q - 4'd1;
      if (tens_q == 4'd0) begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    secs_d   = secs_q;
    min_d    = min_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tup_d    = 1'b0;
    load     = 1'b0;
    load_val = secs_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRunning;
          load     = 1'b1;
          load_val = StartVal;
        end
      end
      StRunning: begin
        if (one_second_enable && add_time) begin
          load     = 1'b1;
          load_val = saturate(sum_dec_add);
        end else if (one_second_enable) begin
          if (secs_q <= 10'd1) begin
            secs_d  = 10'd0;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = StExpired;
            tup_d   = 1'b1;
          end else begin
            secs_d = secs_q - 10'd1;
            min_d  = dec_min;
            tens_d = dec_tens;
            ones_d = dec_ones;
          end
        end else if (add_time) begin
          load     = 1'b1;
          load_val = saturate(sum_add);
        end
        // Expiry takes precedence over a coincident pause.
        if (pause && (state_d == StRunning)) state_d = StPaused;
      end
      StPaused: begin
        if (add_time) begin
          load     = 1'b1;
          load_val = saturate(sum_add);
        end
        if (pause) state_d = StRunning;
      end
      StExpired: begin
        secs_d = 10'd0;
        min_d  = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
        if (start) begin
          state_d  = StRunning;
          load     = 1'b1;
          load_val = StartVal;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      secs_d                   = load_val;
      {min_d, tens_d, ones_d}  = to_bcd(load_val);
    end

    run_d  = (state_d == StRunning);
    warn_d = ((state_d == StRunning) || (state_d == StPaused)) &&
             (secs_d != 10'd0) && (secs_d <= 10'(WARN_SECONDS));
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q                    <= StIdle;
      secs_q                     <= StartVal;
      {min_q, tens_q, ones_q}    <= StartBcd;
      run_q                      <= 1'b0;
      warn_q                     <= 1'b0;
      tup_q                      <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      run_q   <= run_d;
      warn_q  <= warn_d;
      tup_q   <= tup_d;
    end
  end

  assign seconds_left = secs_q;
  assign minutes      = min_q;
  assign sec_tens     = tens_q;
  assign sec_ones     = ones_q;
  assign running      = run_q;
  assign warning      = warn_q;
  assign time_up      = tup_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: directed round scenarios followed by random
// pulse traffic, all checked against a seconds-level behavioural model.
module tb_game_countdown_timer;

  localparam int START = 60;
  localparam int MAXS  = 599;
  localparam int WARN  = 10;
  localparam int BONUS = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, start = 1'b0, pause = 1'b0, add_time = 1'b0;
  logic [9:0] seconds_left;
  logic [3:0] minutes, sec_tens, sec_ones;
  logic       running, warning, time_up;
  logic [1:0] state;

  game_countdown_timer #(
    .START_SECONDS(START),
    .MAX_SECONDS  (MAXS),
    .WARN_SECONDS (WARN),
    .BONUS_SECONDS(BONUS)
  ) dut (
    .clock_100Mhz     (clk),
    .reset            (reset),
    .one_second_enable(tick),
    .start            (start),
    .pause            (pause),
    .add_time         (add_time),
    .seconds_left     (seconds_left),
    .minutes          (minutes),
    .sec_tens         (sec_tens),
    .sec_ones         (sec_ones),
    .running          (running),
    .warning          (warning),
    .time_up          (time_up),
    .state            (state)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 running, 2 paused, 3 expired.
  int    m_state, m_secs, m_tup;
  int    checks = 0, failures = 0, tup_seen = 0;
  string phase = "reset";

  function automatic int cap(input int v);
    return (v > MAXS) ? MAXS : v;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_secs  = START;
    m_tup   = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit a, input bit t);
    m_tup = 0;
    case (m_state)
      0: if (s) begin m_state = 1; m_secs = START; end
      1: begin
        if (t && a) m_secs = cap(m_secs - 1 + BONUS);
        else if (t) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin m_state = 3; m_tup = 1; end
        end else if (a) m_secs = cap(m_secs + BONUS);
        if (p && m_state == 1) m_state = 2;
      end
      2: begin
        if (a) m_secs = cap(m_secs + BONUS);
        if (p) m_state = 1;
      end
      default: if (s) begin m_state = 1; m_secs = START; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s got=%0d exp=%0d", phase, tag, got, exp);
    end
  endtask

  task automatic check_all();
    int warn_exp;
    warn_exp = ((m_state == 1 || m_state == 2) && m_secs >= 1 && m_secs <= WARN) ? 1 : 0;
    check("seconds_left", 32'(seconds_left), m_secs);
    check("minutes", 32'(minutes), m_secs / 60);
    check("sec_tens", 32'(sec_tens), (m_secs % 60) / 10);
    check("sec_ones", 32'(sec_ones), m_secs % 10);
    check("state", 32'(state), m_state);
    check("running", 32'(running), (m_state == 1) ? 1 : 0);
    check("warning", 32'(warning), warn_exp);
    check("time_up", 32'(time_up), m_tup);
    if (time_up === 1'b1) tup_seen++;
  endtask

  task automatic step(input bit s, input bit p, input bit a, input bit t);
    @(negedge clk);
    start = s; pause = p; add_time = a; tick = t;
    @(posedge clk);
    model_step(s, p, a, t);
    #1;
    start = 0; pause = 0; add_time = 0; tick = 0;
    check_all();
  endtask

  // One tick followed by a quiet cycle.
  task automatic tick_gap();
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Full round to expiry.
    phase = "round";
    step(0, 1, 1, 1);  // idle ignores everything but start
    step(1, 0, 0, 0);
    tup_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      tick_gap();
      if (i == 59) begin
        check("d59_min", 32'(minutes), 0);
        check("d59_ones", 32'(sec_ones), 1);
      end
    end
    check("tup_count", tup_seen, 1);
    check("expired_state", 32'(state), 3);

    // Warning and pause behaviour.
    phase = "warn";
    step(1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 1);
    check("warn_at_10", 32'(warning), 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick_gap();
    check("paused_hold", 32'(seconds_left), 10);
    step(1, 0, 0, 0);  // start ignored while paused
    step(0, 1, 0, 0);
    tick_gap();
    check("resume_dec", 32'(seconds_left), 9);

    // Saturation.
    phase = "sat";
    step(1, 0, 0, 0);  // ignored in running
    for (int i = 0; i < 40; i++) step(0, 0, 1, 0);
    check("sat_val", 32'(seconds_left), 599);
    step(0, 0, 1, 0);
    check("sat_hold", 32'(seconds_left), 599);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);  // add while paused at ceiling
    step(0, 1, 0, 1);  // pause + tick in paused: resume only

    // Tick + add at one second left, then tick + pause with expiry.
    phase = "edge";
    reset = 1'b1; #1; model_reset(); check_all();
    @(negedge clk); reset = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
    tup_seen = 0;
    step(0, 0, 1, 1);
    check("add_tick_val", 32'(seconds_left), 15);
    for (int i = 0; i < 14; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 1);  // expiry beats pause
    check("exp_over_pause", 32'(state), 3);
    check("edge_tups", tup_seen, 1);

    // Expired is sticky until start.
    phase = "expired";
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 1);
    step(1, 1, 1, 0);  // start wins over pause/add
    check("restart", 32'(seconds_left), 60);

    // Asynchronous reset mid-round.
    phase = "async";
    for (int i = 0; i < 37; i++) step(0, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Random pulse traffic.
    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
Round countdown timer for the crane game. It consumes the one-cycle 1 Hz `one_second_enable` strobe from the timing block and counts remaining play time down to zero. It exposes the remaining time as a binary count and as BCD minute/second digits for the display driver. It also produces a one-cycle `time_up` pulse that the game FSM uses to force the claw drop.

Parameters:
START_SECONDS, 60, seconds loaded on start (1..MAX_SECONDS)
MAX_SECONDS, 599, saturation ceiling (9:59); must be < 1024
WARN_SECONDS, 10, warning threshold
BONUS_SECONDS, 15, seconds added per add_time pulse

Ports:
clock_100Mhz  input  1   system clock, 100 MHz
reset  input  1   asynchronous, active-high reset
one_second_enable  input  1   1-cycle tick, one per second
start  input  1   1-cycle pulse: begin a new round
pause  input  1   1-cycle pulse: toggle RUNNING/PAUSED
add_time  input  1   1-cycle pulse: add BONUS_SECONDS
seconds_left  output  10  remaining seconds, binary
minutes  output  4   BCD minutes (0..9)
sec_tens  output  4   BCD tens of seconds (0..5)
sec_ones  output  4   BCD ones of seconds (0..9)
running  output  1   high in RUNNING
warning  output  1   high in RUNNING/PAUSED when 1 <= seconds_left <= WARN_SECONDS
time_up  output  1   1-cycle pulse on expiry
state  output  2   IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3

Behaviour:
- Clock and reset: single clock `clock_100Mhz`. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, seconds_left=START_SECONDS, BCD digits equal START_SECONDS (60 -> 1/0/0), running=0, warning=0, time_up=0.
- Reset mid-round: aborts immediately to the reset values. No time_up is generated.
- IDLE:
  - start -> RUNNING; seconds_left reloaded with START_SECONDS.
  - pause, add_time and ticks are ignored.
- RUNNING:
  - tick: seconds_left decrements by 1 on the edge that samples one_second_enable=1.
  - Tick with seconds_left==1: seconds_left becomes 0 and state becomes EXPIRED. time_up=1 on that same edge, for exactly one cycle.
  - pause -> PAUSED.
  - start is ignored.
- PAUSED:
  - ticks are ignored; seconds_left is held.
  - pause -> RUNNING.
  - add_time is honoured.
  - start is ignored.
- EXPIRED:
  - seconds_left=0.
  - start -> RUNNING with START_SECONDS. This is the only exit other than reset.
  - pause, add_time and ticks are ignored.
- add_time (RUNNING/PAUSED only): seconds_left = min(seconds_left + BONUS_SECONDS, MAX_SECONDS). Sum width is 11 bits, then saturated.
- Simultaneous events, evaluated in one cycle with this priority:
  - start in IDLE/EXPIRED overrides pause and add_time.
  - In RUNNING, tick and add_time together: next = min(seconds_left - 1 + BONUS_SECONDS, MAX_SECONDS). No expiry, even at seconds_left==1.
  - In RUNNING, tick and pause together: the decrement applies (including expiry, which wins over pause), then state = PAUSED.
- BCD outputs:
  - Updated on the same edge as seconds_left, with zero skew; they always satisfy minutes*60 + sec_tens*10 + sec_ones == seconds_left.
  - Maintained as cascaded digit counters on decrement: borrow ones 0->9, tens 0->5, minutes -1.
  - On a load or add, the digits are recomputed from the new binary value via a divide-by-60/10 conversion. Multi-cycle conversion is permitted only if the outputs stay consistent; the preferred implementation is a combinational conversion of the next value registered alongside it.
- Ticks never arrive back to back, but the logic must not rely on that.
- Derived flags: running = (state==RUNNING). warning is computed from the next-state value (registered, same edge).

Test Plan:
- Reset, then start, then 60 ticks -> seconds_left 59, 58, …, 0. BCD digits at the 59th tick are 0/0/1. time_up is high for exactly 1 cycle on the 60th tick; state=3; total time_up count is 1.
- Start, 50 ticks (seconds_left=10) -> warning rises on the 50th tick. Pause, then 5 ticks -> seconds_left stays 10, state=2, warning=1. Pause again, 1 tick -> 9.
- Start, add_time x40 -> seconds_left saturates at 599; digits 9/5/9. A further add_time -> unchanged.
- seconds_left=1 with add_time and tick in the same cycle -> seconds_left=15, state stays RUNNING, no time_up.
- In EXPIRED, apply pause, add_time and ticks -> no change. Then start -> seconds_left=60, RUNNING.
- Assert reset asynchronously mid-cycle at seconds_left=23 -> outputs return to reset values before the next edge; no time_up pulse.
